// File: rtl/udp_row_rx_if.sv
// Byte-stream and row-output bundle for udp_row_rx: GMII receive side in, packed row bytes and
// per-frame status out.
interface udp_row_rx_if #(
  parameter int unsigned IMAGE_WIDTH = 1280
);
  localparam int unsigned ADDR_W = $clog2(IMAGE_WIDTH / 8);

  logic              gmii_rx_dv;
  logic [7:0]        gmii_rxd;
  logic [7:0]        pix_byte;
  logic              pix_byte_valid;
  logic [ADDR_W-1:0] pix_byte_addr;
  logic [15:0]       row_index;
  logic              row_start;
  logic              row_done;
  logic              row_ok;
  logic [15:0]       drop_cnt;

  modport master (
    output gmii_rx_dv, gmii_rxd,
    input  pix_byte, pix_byte_valid, pix_byte_addr, row_index, row_start, row_done, row_ok,
           drop_cnt
  );

  modport slave (
    input  gmii_rx_dv, gmii_rxd,
    output pix_byte, pix_byte_valid, pix_byte_addr, row_index, row_start, row_done, row_ok,
           drop_cnt
  );
endinterface

// File: rtl/udp_row_rx.sv
// GMII Ethernet/IPv4/UDP receiver that extracts one binarised image row per frame.
// Define CRC_CHECK_EN to qualify row_ok with the frame CRC-32 residue.
module udp_row_rx #(
  parameter int unsigned IMAGE_WIDTH    = 1280,
  parameter int unsigned DATA_LENGTH    = IMAGE_WIDTH / 8 + 2,
  parameter logic [47:0] LOCAL_MAC      = 48'h00_0a_35_01_fe_c0,
  parameter logic [31:0] LOCAL_IP       = 32'hc0_a8_00_03,
  parameter logic [15:0] LOCAL_UDP_PORT = 16'd6102
) (
  input logic         clk,
  input logic         rst_p,
  udp_row_rx_if.slave bus
);
  localparam int unsigned PixBytes = IMAGE_WIDTH / 8;
  localparam int unsigned ADDR_W   = $clog2(PixBytes);
  localparam int unsigned CntW     = (ADDR_W > 5) ? ADDR_W : 5;
  localparam logic [15:0] IpTotLen = 16'(DATA_LENGTH + 28);
  localparam logic [15:0] UdpLen   = 16'(DATA_LENGTH + 8);
  localparam logic [CntW-1:0] LastPix = CntW'(PixBytes - 1);

  typedef enum logic [3:0] {
    StIdle, StPreamble, StEthHdr, StIpHdr, StUdpHdr, StRowIdx, StPayload, StFcs, StTail, StDrop
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              dv_q, mac_loc_q, mac_bc_q;
  logic [7:0]        row_hi_q;
  logic [7:0]        pix_byte_q;
  logic              pix_valid_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [15:0]       row_index_q;
  logic              row_start_q, row_done_q, row_ok_q;
  logic [15:0]       drop_cnt_q;

  logic       dv;
  logic [7:0] rxd;
  logic       hdr_bad, mac_loc_d, mac_bc_d, drop_inc, crc_good;
  logic [7:0] mac_byte;

  assign dv  = bus.gmii_rx_dv;
  assign rxd = bus.gmii_rxd;

  // hdr_bad flags the current byte as a reason to abandon the frame in the current state.
  always_comb begin
    hdr_bad  = 1'b0;
    mac_byte = 8'h00;
    for (int i = 0; i < 6; i++) if (cnt_q == CntW'(i)) mac_byte = LOCAL_MAC[47-8*i -: 8];
    mac_loc_d = (cnt_q == '0 || mac_loc_q) && rxd == mac_byte;
    mac_bc_d  = (cnt_q == '0 || mac_bc_q) && rxd == 8'hff;
    case (state_q)
      StIdle:     hdr_bad = rxd != 8'h55 && rxd != 8'hd5;
      StPreamble: hdr_bad = rxd != 8'hd5 && !(rxd == 8'h55 && cnt_q < CntW'(6));
      StEthHdr: begin
        if (cnt_q < CntW'(6))        hdr_bad = !(mac_loc_d || mac_bc_d);
        else if (cnt_q == CntW'(12)) hdr_bad = rxd != 8'h08;
        else if (cnt_q == CntW'(13)) hdr_bad = rxd != 8'h00;
      end
      StIpHdr: begin
        if (cnt_q == CntW'(0))      hdr_bad = rxd != 8'h45;
        else if (cnt_q == CntW'(2)) hdr_bad = rxd != IpTotLen[15:8];
        else if (cnt_q == CntW'(3)) hdr_bad = rxd != IpTotLen[7:0];
        else if (cnt_q == CntW'(9)) hdr_bad = rxd != 8'h11;
        for (int i = 0; i < 4; i++) begin
          if (cnt_q == CntW'(16 + i)) hdr_bad = rxd != LOCAL_IP[31-8*i -: 8];
        end
      end
      StUdpHdr: begin
        if (cnt_q == CntW'(2))      hdr_bad = rxd != LOCAL_UDP_PORT[15:8];
        else if (cnt_q == CntW'(3)) hdr_bad = rxd != LOCAL_UDP_PORT[7:0];
        else if (cnt_q == CntW'(4)) hdr_bad = rxd != UdpLen[15:8];
        else if (cnt_q == CntW'(5)) hdr_bad = rxd != UdpLen[7:0];
      end
      default: hdr_bad = 1'b0;
    endcase
  end

  assign drop_inc = (dv && hdr_bad && (state_q != StIdle || !dv_q))
                 || (!dv && state_q inside {StEthHdr, StIpHdr, StUdpHdr, StRowIdx, StPayload, StFcs})
                 || (!dv && state_q == StTail && !crc_good);

`ifdef CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q ^ {24'h0, rxd};
    for (int i = 0; i < 8; i++) crc_d = crc_d[0] ? ((crc_d >> 1) ^ 32'hedb8_8320) : (crc_d >> 1);
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      crc_q <= '1;
    end else if (state_q inside {StIdle, StPreamble}) begin
      crc_q <= '1;
    end else if (dv && state_q inside {StEthHdr, StIpHdr, StUdpHdr, StRowIdx, StPayload, StFcs}) begin
      crc_q <= crc_d;
    end
  end

  // Shift-right register form of the 0xC704DD7B residue.
  assign crc_good = crc_q == 32'hdebb_20e3;
`else
  assign crc_good = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dv_q        <= 1'b1;  // a frame already in flight at release must not look like a new edge
      mac_loc_q   <= 1'b0;
      mac_bc_q    <= 1'b0;
      row_hi_q    <= 8'h00;
      pix_byte_q  <= 8'h00;
      pix_valid_q <= 1'b0;
      pix_addr_q  <= '0;
      row_index_q <= 16'h0000;
      row_start_q <= 1'b0;
      row_done_q  <= 1'b0;
      row_ok_q    <= 1'b0;
      drop_cnt_q  <= 16'h0000;
    end else begin
      dv_q        <= dv;
      pix_valid_q <= 1'b0;
      row_start_q <= 1'b0;
      row_done_q  <= 1'b0;
      row_ok_q    <= 1'b0;
      if (dv) cnt_q <= cnt_q + 1'b1;
      if (drop_inc && drop_cnt_q != 16'hffff) drop_cnt_q <= drop_cnt_q + 1'b1;

      if (state_q != StIdle && !dv) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        if (state_q inside {StRowIdx, StPayload, StFcs, StTail}) begin
          row_done_q <= 1'b1;
          row_ok_q   <= (state_q == StTail) && crc_good;
        end
      end else if (state_q != StIdle && hdr_bad) begin
        state_q <= StDrop;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (dv && !dv_q) begin
              cnt_q <= '0;
              if (hdr_bad)            state_q <= StDrop;
              else if (rxd == 8'hd5)  state_q <= StEthHdr;
              else                    state_q <= StPreamble;
            end
          end
          StPreamble: begin
            if (rxd == 8'hd5) begin
              state_q <= StEthHdr;
              cnt_q   <= '0;
            end
          end
          StEthHdr: begin
            mac_loc_q <= mac_loc_d;
            mac_bc_q  <= mac_bc_d;
            if (cnt_q == CntW'(13)) begin
              state_q <= StIpHdr;
              cnt_q   <= '0;
            end
          end
          StIpHdr: begin
            if (cnt_q == CntW'(19)) begin
              state_q <= StUdpHdr;
              cnt_q   <= '0;
            end
          end
          StUdpHdr: begin
            if (cnt_q == CntW'(7)) begin
              state_q <= StRowIdx;
              cnt_q   <= '0;
            end
          end
          StRowIdx: begin
            if (cnt_q == '0) begin
              row_hi_q <= rxd;
            end else begin
              row_index_q <= {row_hi_q, rxd};
              row_start_q <= 1'b1;
              state_q     <= StPayload;
              cnt_q       <= '0;
            end
          end
          StPayload: begin
            pix_byte_q  <= rxd;
            pix_valid_q <= 1'b1;
            pix_addr_q  <= ADDR_W'(cnt_q);
            if (cnt_q == LastPix) begin
              state_q <= StFcs;
              cnt_q   <= '0;
            end
          end
          StFcs: begin
            if (cnt_q == CntW'(3)) begin
              state_q <= StTail;
              cnt_q   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.pix_byte       = pix_byte_q;
  assign bus.pix_byte_valid = pix_valid_q;
  assign bus.pix_byte_addr  = pix_addr_q;
  assign bus.row_index      = row_index_q;
  assign bus.row_start      = row_start_q;
  assign bus.row_done       = row_done_q;
  assign bus.row_ok         = row_ok_q;
  assign bus.drop_cnt       = drop_cnt_q;
endmodule
